// File: rtl/risc_fetch_unit.sv
// risc_fetch_unit
//   Instruction-fetch and program-counter sequencer for the 16-bit RISC CPU.
//   Fetches one instruction at a time over a req/ack handshake, presents it for
//   decode, waits for the datapath to finish, then computes the next PC from the
//   jump/branch controls and the ALU zero flag.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for run; no memory request
//   FETCH  | imem_req high, imem_addr = pc; latch instruction on imem_ack
//   DECODE | instr_valid pulse; instr/opcode handed to risc_control
//   EXEC   | wait for exec_done, then update pc and fetch again
//
// Ports
//   clk, rst               clock, async active-high reset
//   run                    start fetching from IDLE
//   imem_req/addr/ack/rdata instruction-memory handshake
//   instr, opcode          latched instruction and its opcode field
//   instr_valid            one-cycle pulse in DECODE
//   jmp, beq, bne          control-flow requests from risc_control
//   alu_zero               ALU zero flag for the executing instruction
//   exec_done              datapath completion, honoured in EXEC only
//   pc                     current program counter

module risc_fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ack,
   input  logic [15:0] imem_rdata,
   output logic [15:0] instr,
   output logic [3:0]  opcode,
   output logic        instr_valid,
   input  logic        jmp,
   input  logic        beq,
   input  logic        bne,
   input  logic        alu_zero,
   input  logic        exec_done,
   output logic [15:0] pc
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_DECODE = 2'd2,
      ST_EXEC   = 2'd3
   } state_t;

   state_t      state;
   logic [15:0] pc2;
   logic [15:0] br_off;
   logic [15:0] br_tgt;
   logic [15:0] jmp_tgt;
   logic [15:0] next_pc;

   assign pc2     = pc + 16'd2;
   // Word offset in instr[5:0], sign-extended and scaled to bytes.
   assign br_off  = {{9{instr[5]}}, instr[5:0], 1'b0};
   assign br_tgt  = pc2 + br_off;
   // Jump stays inside the 8 KiB region of the sequential PC.
   assign jmp_tgt = {pc2[15:13], instr[11:0], 1'b0};

   always_comb begin
      next_pc = pc2;
      if (jmp)
         next_pc = jmp_tgt;
      else if (beq && alu_zero)
         next_pc = br_tgt;
      else if (bne && !alu_zero)
         next_pc = br_tgt;
   end

   assign imem_addr = pc;
   assign opcode    = instr[15:12];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         pc          <= RESET_PC;
         instr       <= 16'h0000;
         imem_req    <= 1'b0;
         instr_valid <= 1'b0;
      end else begin
         instr_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (run) begin
                  state    <= ST_FETCH;
                  imem_req <= 1'b1;
               end
            end
            ST_FETCH: begin
               if (imem_ack) begin
                  instr       <= imem_rdata;
                  imem_req    <= 1'b0;
                  instr_valid <= 1'b1;
                  state       <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               state <= ST_EXEC;
            end
            ST_EXEC: begin
               if (exec_done) begin
                  pc       <= next_pc;
                  imem_req <= 1'b1;
                  state    <= ST_FETCH;
               end
            end
            default: begin
               state    <= ST_IDLE;
               imem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_risc_fetch_unit.sv
// tb_risc_fetch_unit
//   Directed bench for risc_fetch_unit. Two instances share all inputs: u_dut
//   resets to 0x0000, u_dut_hi resets to 0x4000 so jumps in the upper region
//   can be observed from the very first instruction.

module tb_risc_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic        jmp, beq, bne, alu_zero, exec_done;

   logic        imem_req,    imem_req_hi;
   logic [15:0] imem_addr,   imem_addr_hi;
   logic [15:0] instr,       instr_hi;
   logic [3:0]  opcode,      opcode_hi;
   logic        instr_valid, instr_valid_hi;
   logic [15:0] pc,          pc_hi;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   risc_fetch_unit #(.RESET_PC(16'h0000)) u_dut (
      .clk(clk), .rst(rst), .run(run),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr(instr), .opcode(opcode), .instr_valid(instr_valid),
      .jmp(jmp), .beq(beq), .bne(bne), .alu_zero(alu_zero), .exec_done(exec_done),
      .pc(pc)
   );

   risc_fetch_unit #(.RESET_PC(16'h4000)) u_dut_hi (
      .clk(clk), .rst(rst), .run(run),
      .imem_req(imem_req_hi), .imem_addr(imem_addr_hi), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr(instr_hi), .opcode(opcode_hi), .instr_valid(instr_valid_hi),
      .jmp(jmp), .beq(beq), .bne(bne), .alu_zero(alu_zero), .exec_done(exec_done),
      .pc(pc_hi)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Entered and left at a falling edge with the FSM in FETCH.
   task automatic do_instr(input string tag, input logic [15:0] word, input int wait_n,
                           input logic j, input logic b, input logic n, input logic z,
                           input logic noise, input logic [15:0] exp_pc);
      logic [15:0] pc_before;
      pc_before = pc;
      for (int i = 0; i < wait_n; i++) begin
         check({tag, "_req_wait"}, 32'(imem_req), 32'd1);
         @(negedge clk);
      end
      check({tag, "_req"}, 32'(imem_req), 32'd1);
      imem_ack   = 1'b1;
      imem_rdata = word;
      @(negedge clk);
      imem_ack   = 1'b0;
      imem_rdata = 16'hDEAD;
      check({tag, "_valid"},  32'(instr_valid), 32'd1);
      check({tag, "_instr"},  32'(instr), 32'(word));
      check({tag, "_opcode"}, 32'(opcode), 32'(word[15:12]));
      check({tag, "_req_lo"}, 32'(imem_req), 32'd0);
      if (noise) begin
         exec_done = 1'b1;
         imem_ack  = 1'b1;
      end
      @(negedge clk);
      exec_done = 1'b0;
      imem_ack  = 1'b0;
      check({tag, "_valid_once"}, 32'(instr_valid), 32'd0);
      if (noise) begin
         @(negedge clk);
         check({tag, "_noise_pc"},    32'(pc), 32'(pc_before));
         check({tag, "_noise_req"},   32'(imem_req), 32'd0);
         check({tag, "_noise_instr"}, 32'(instr), 32'(word));
      end
      jmp = j; beq = b; bne = n; alu_zero = z;
      exec_done = 1'b1;
      @(negedge clk);
      exec_done = 1'b0;
      jmp = 1'b0; beq = 1'b0; bne = 1'b0; alu_zero = 1'b0;
      check({tag, "_pc"},   32'(pc), 32'(exp_pc));
      check({tag, "_addr"}, 32'(imem_addr), 32'(exp_pc));
      check({tag, "_refetch"}, 32'(imem_req), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; run = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0000;
      jmp = 1'b0; beq = 1'b0; bne = 1'b0; alu_zero = 1'b0; exec_done = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_pc",    32'(pc), 32'h0000);
      check("rst_instr", 32'(instr), 32'h0000);
      check("rst_req",   32'(imem_req), 32'd0);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_pc_hi", 32'(pc_hi), 32'h4000);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_req", 32'(imem_req), 32'd0);

      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      check("fetch_addr", 32'(imem_addr), 32'h0000);

      do_instr("jmp",     16'hD123, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0246);
      check("jmp_pc_hi", 32'(pc_hi), 32'h4246);
      do_instr("jmp_beq", 16'hD008, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0010);
      check("jmp_beq_pc_hi", 32'(pc_hi), 32'h4010);
      do_instr("beq_t",   16'hB03E, 1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h000E);
      check("beq_t_pc_hi", 32'(pc_hi), 32'h400E);
      do_instr("seq",     16'h2123, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0010);
      do_instr("beq_nt",  16'hB03E, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0012);
      do_instr("jmp2",    16'hD010, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0020);
      do_instr("bne_t",   16'hC005, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h002C);
      do_instr("bne_nt",  16'hC005, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'h002E);

      // Reset in the middle of a fetch must drop the request immediately.
      check("midfetch_req", 32'(imem_req), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("async_req",   32'(imem_req), 32'd0);
      check("async_pc",    32'(pc), 32'h0000);
      check("async_instr", 32'(instr), 32'h0000);
      check("async_pc_hi", 32'(pc_hi), 32'h4000);
      @(negedge clk);
      rst = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = 16'hFFFF;
      exec_done  = 1'b1;
      @(negedge clk);
      imem_ack  = 1'b0;
      exec_done = 1'b0;
      check("idle_ack_req",   32'(imem_req), 32'd0);
      check("idle_ack_instr", 32'(instr), 32'h0000);
      check("idle_ack_valid", 32'(instr_valid), 32'd0);
      check("idle_ack_pc",    32'(pc), 32'h0000);

      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
      do_instr("beq_wrap", 16'hB03E, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFE);
      do_instr("pc_wrap",  16'h1000, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
